// File: rtl/html_layout_stack.sv
// Layout-context engine: a DEPTH-deep stack of cursor/style contexts for nested div/p tags.
// Optional HTML_LINE_WRAP_EN wraps the text cursor at SCREEN_W instead of letting cur_x roll over.
module html_layout_stack #(
    parameter int DEPTH    = 8,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 3,
    parameter int VAL_W    = 9,
    parameter int FONT_W   = 8,
    parameter int FONT_H   = 8,
    parameter int KERN     = 1,
    parameter int SCREEN_W = 320
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tag_start,
    input  logic                       tag_is_block,
    input  logic                       attr_valid,
    input  logic [2:0]                 attr_type,
    input  logic [VAL_W-1:0]           attr_value,
    input  logic                       tag_end,
    input  logic                       close_valid,
    input  logic                       glyph_adv,
    input  logic                       rect_done,
    output logic [X_W-1:0]             cur_x,
    output logic [Y_W-1:0]             cur_y,
    output logic [COLOR_W-1:0]         cur_color,
    output logic [VAL_W-1:0]           cur_size,
    output logic [X_W-1:0]             rect_x,
    output logic [Y_W-1:0]             rect_y,
    output logic [X_W-1:0]             rect_w,
    output logic [Y_W-1:0]             rect_h,
    output logic [COLOR_W-1:0]         rect_bg,
    output logic [COLOR_W-1:0]         rect_border_color,
    output logic                       rect_has_border,
    output logic                       rect_start,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       overflow_err,
    output logic                       underflow_err,
    output logic                       proto_err
);
    localparam int DW     = $clog2(DEPTH + 1);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SKIP_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_ATTR, S_EMIT, S_WAIT} state_t;

    typedef struct packed {
        logic [X_W-1:0]     cx;
        logic [Y_W-1:0]     cy;
        logic [X_W-1:0]     lx;
        logic [COLOR_W-1:0] color;
        logic [VAL_W-1:0]   size;
        logic [VAL_W-1:0]   padding;
        logic [VAL_W-1:0]   margin;
        logic [X_W-1:0]     bx;
        logic [Y_W-1:0]     by;
        logic [X_W-1:0]     rw;
        logic [Y_W-1:0]     rh;
    } ctx_t;

    function automatic logic [VAL_W-1:0] clamp_size(input logic [VAL_W-1:0] v);
        return (v == '0) ? VAL_W'(1) : v;
    endfunction

    function automatic logic [X_W-1:0] glyph_step(input logic [VAL_W-1:0] size);
        return X_W'((FONT_W + KERN) * int'(size));
    endfunction

    function automatic logic [Y_W-1:0] row_height(input logic [VAL_W-1:0] size);
        return Y_W'(int'(size) * FONT_H);
    endfunction

`ifdef HTML_LINE_WRAP_EN
    function automatic logic line_full(input logic [X_W-1:0] cx, input logic [VAL_W-1:0] size);
        return (int'(cx) + 2 * (FONT_W + KERN) * int'(size)) > (SCREEN_W - 1);
    endfunction
`endif

    state_t              state, state_n;
    ctx_t                w, w_n, top;
    ctx_t                stack [DEPTH];
    logic                blk, blk_n, discard, disc_n, push;
    logic [SKIP_W-1:0]   skip, skip_n;
    logic [DW-1:0]       depth_n;
    logic [X_W-1:0]      rx_n;
    logic [Y_W-1:0]      ry_n;
    logic [COLOR_W-1:0]  bg_n, bc_n;
    logic                hb_n, oerr_n, uerr_n, proto_hit;

    assign top = stack[AW'(depth - DW'(1))];

    // The popped cursor and block geometry are recomputed from the inner context, not restored.
    logic unused_top;
    assign unused_top = ^{top.cx, top.cy, top.bx, top.by, top.rw, top.rh};

    assign cur_x     = w.cx;
    assign cur_y     = w.cy;
    assign cur_color = w.color;
    assign cur_size  = w.size;
    assign rect_w    = w.rw;
    assign rect_h    = w.rh;
    assign busy      = (state != S_IDLE);

    always_comb begin
        proto_hit = 1'b0;
        case (state)
            S_ATTR: proto_hit = tag_start | close_valid | glyph_adv | rect_done;
            S_EMIT: proto_hit = tag_start | close_valid | glyph_adv | rect_done | attr_valid | tag_end;
            S_WAIT: proto_hit = tag_start | close_valid | glyph_adv | attr_valid | tag_end;
            default: proto_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (!close_valid && tag_start) state_n = S_ATTR;
            S_ATTR: if (tag_end) state_n = (blk && !discard) ? S_EMIT : S_IDLE;
            S_EMIT: state_n = S_WAIT;
            S_WAIT: if (rect_done) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_n     = w;
        blk_n   = blk;
        disc_n  = discard;
        skip_n  = skip;
        depth_n = depth;
        rx_n    = rect_x;
        ry_n    = rect_y;
        bg_n    = rect_bg;
        bc_n    = rect_border_color;
        hb_n    = rect_has_border;
        oerr_n  = overflow_err;
        uerr_n  = underflow_err;
        push    = 1'b0;
        case (state)
            S_IDLE: begin
                if (close_valid) begin
                    if (skip != '0) begin
                        skip_n = skip - SKIP_W'(1);
                    end else if (depth == '0) begin
                        uerr_n = 1'b1;
                    end else begin
                        depth_n = depth - DW'(1);
                        w_n.cx  = top.lx;
                        w_n.lx  = top.lx;
                        if (tag_is_block) begin
                            w_n.cy = w.by + w.rh + Y_W'(w.margin);
                            w_n.bx = top.lx;
                            w_n.by = w.by + w.rh + Y_W'(w.margin);
                        end else begin
                            w_n.cy = w.cy + row_height(w.size);
                        end
                        w_n.color   = top.color;
                        w_n.size    = top.size;
                        w_n.padding = top.padding;
                        w_n.margin  = top.margin;
                    end
                end else if (tag_start) begin
                    blk_n = tag_is_block;
                    if (depth < DW'(DEPTH)) begin
                        push    = 1'b1;
                        depth_n = depth + DW'(1);
                        disc_n  = 1'b0;
                    end else begin
                        oerr_n = 1'b1;
                        skip_n = skip + SKIP_W'(1);
                        disc_n = 1'b1;
                    end
                end else if (glyph_adv) begin
`ifdef HTML_LINE_WRAP_EN
                    if (line_full(w.cx, w.size)) begin
                        w_n.cx = w.lx;
                        w_n.cy = w.cy + row_height(w.size);
                    end else
`endif
                    w_n.cx = w.cx + glyph_step(w.size);
                end
            end
            S_ATTR: begin
                if (attr_valid && !discard) begin
                    case (attr_type)
                        3'd0: w_n.color = COLOR_W'(attr_value);
                        3'd1: w_n.size  = clamp_size(attr_value);
                        3'd2: w_n.rw    = X_W'(attr_value);
                        3'd3: w_n.rh    = Y_W'(attr_value);
                        3'd4: bg_n      = COLOR_W'(attr_value);
                        3'd5: begin
                            w_n.padding = attr_value;
                            w_n.cx      = w.cx + X_W'(attr_value);
                            w_n.cy      = w.cy + Y_W'(attr_value);
                        end
                        3'd6: begin
                            w_n.margin = attr_value;
                            w_n.bx     = w.bx + X_W'(attr_value);
                            w_n.by     = w.by + Y_W'(attr_value);
                        end
                        default: begin
                            hb_n = 1'b1;
                            bc_n = COLOR_W'(attr_value);
                        end
                    endcase
                end
                if (tag_end && blk && !discard) begin
                    rx_n = w.bx;
                    ry_n = w.by;
                end
            end
            S_WAIT: begin
                if (rect_done) begin
                    w_n.cx = w.bx + X_W'(w.padding);
                    w_n.cy = w.by + Y_W'(w.padding);
                    w_n.lx = w.bx + X_W'(w.padding);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) stack[AW'(depth)] <= w;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w                 <= '0;
            w.size            <= VAL_W'(1);
            blk               <= 1'b0;
            discard           <= 1'b0;
            skip              <= '0;
            depth             <= '0;
            rect_x            <= '0;
            rect_y            <= '0;
            rect_bg           <= '0;
            rect_border_color <= '0;
            rect_has_border   <= 1'b0;
            rect_start        <= 1'b0;
            overflow_err      <= 1'b0;
            underflow_err     <= 1'b0;
            proto_err         <= 1'b0;
        end else begin
            w                 <= w_n;
            blk               <= blk_n;
            discard           <= disc_n;
            skip              <= skip_n;
            depth             <= depth_n;
            rect_x            <= rx_n;
            rect_y            <= ry_n;
            rect_bg           <= bg_n;
            rect_border_color <= bc_n;
            rect_has_border   <= hb_n;
            rect_start        <= (state == S_EMIT);
            overflow_err      <= oerr_n;
            underflow_err     <= uerr_n;
            proto_err         <= proto_err | proto_hit;
        end
    end
endmodule

// File: tb/tb_html_layout_stack.sv
// Directed bench for html_layout_stack: a queue-based layout model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_html_layout_stack;
    localparam int DEPTH = 8, X_W = 9, Y_W = 8, COLOR_W = 3, VAL_W = 9;
    localparam int FONT_W = 8, FONT_H = 8, KERN = 1, SCREEN_W = 320;
    localparam int XM = (1 << X_W) - 1, YM = (1 << Y_W) - 1, CM = (1 << COLOR_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tag_start = 0, tag_is_block = 0, attr_valid = 0, tag_end = 0;
    logic close_valid = 0, glyph_adv = 0, rect_done = 0;
    logic [2:0] attr_type = '0;
    logic [VAL_W-1:0] attr_value = '0;
    logic [X_W-1:0] cur_x, rect_x, rect_w;
    logic [Y_W-1:0] cur_y, rect_y, rect_h;
    logic [COLOR_W-1:0] cur_color, rect_bg, rect_border_color;
    logic [VAL_W-1:0] cur_size;
    logic rect_has_border, rect_start, busy, overflow_err, underflow_err, proto_err;
    logic [$clog2(DEPTH+1)-1:0] depth;

    html_layout_stack #(.DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .VAL_W(VAL_W),
                        .FONT_W(FONT_W), .FONT_H(FONT_H), .KERN(KERN), .SCREEN_W(SCREEN_W)) dut (
        .clock(clock), .reset(reset), .tag_start(tag_start), .tag_is_block(tag_is_block),
        .attr_valid(attr_valid), .attr_type(attr_type), .attr_value(attr_value),
        .tag_end(tag_end), .close_valid(close_valid), .glyph_adv(glyph_adv), .rect_done(rect_done),
        .cur_x(cur_x), .cur_y(cur_y), .cur_color(cur_color), .cur_size(cur_size),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_bg(rect_bg), .rect_border_color(rect_border_color), .rect_has_border(rect_has_border),
        .rect_start(rect_start), .busy(busy), .depth(depth), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .proto_err(proto_err));

    always #5 clock = ~clock;

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int cx, cy, lx, color, size, pad, mar, bx, by, rw, rh;
    } mctx_t;

    mctx_t mw;
    mctx_t mstk[$];
    int mph;  // 0 idle, 1 collecting attributes, 2 about to draw, 3 waiting for renderer
    int mrx, mry, mbg, mbc, mhb, mrs, mblk, mdisc, mskip, moerr, muerr, mperr;

    task automatic model_reset();
        mw = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        mstk.delete();
        mph = 0; mrx = 0; mry = 0; mbg = 0; mbc = 0; mhb = 0; mrs = 0;
        mblk = 0; mdisc = 0; mskip = 0; moerr = 0; muerr = 0; mperr = 0;
    endtask

    task automatic model_close(input int blkc);
        mctx_t p;
        if (mskip > 0) mskip--;
        else if (mstk.size() == 0) muerr = 1;
        else begin
            p = mstk.pop_back();
            if (blkc != 0) begin
                mw.cy = (mw.by + mw.rh + mw.mar) & YM;
                mw.bx = p.lx;
                mw.by = mw.cy;
            end else begin
                mw.cy = (mw.cy + mw.size * FONT_H) & YM;
            end
            mw.cx = p.lx; mw.lx = p.lx;
            mw.color = p.color; mw.size = p.size; mw.pad = p.pad; mw.mar = p.mar;
        end
    endtask

    task automatic model_glyph();
`ifdef HTML_LINE_WRAP_EN
        if (mw.cx + 2 * (FONT_W + KERN) * mw.size > SCREEN_W - 1) begin
            mw.cx = mw.lx;
            mw.cy = (mw.cy + mw.size * FONT_H) & YM;
        end else
`endif
        mw.cx = (mw.cx + (FONT_W + KERN) * mw.size) & XM;
    endtask

    task automatic model_attr(input int t, input int v);
        case (t)
            0: mw.color = v & CM;
            1: mw.size = (v == 0) ? 1 : v;
            2: mw.rw = v & XM;
            3: mw.rh = v & YM;
            4: mbg = v & CM;
            5: begin mw.pad = v; mw.cx = (mw.cx + v) & XM; mw.cy = (mw.cy + v) & YM; end
            6: begin mw.mar = v; mw.bx = (mw.bx + v) & XM; mw.by = (mw.by + v) & YM; end
            default: begin mhb = 1; mbc = v & CM; end
        endcase
    endtask

    task automatic model_update();
        if (reset) begin
            model_reset();
            return;
        end
        mrs = 0;
        case (mph)
            0: begin
                if (close_valid) model_close(int'(tag_is_block));
                else if (tag_start) begin
                    mblk = int'(tag_is_block);
                    mph = 1;
                    if (mstk.size() < DEPTH) begin mstk.push_back(mw); mdisc = 0; end
                    else begin moerr = 1; mskip++; mdisc = 1; end
                end else if (glyph_adv) model_glyph();
            end
            1: begin
                if (tag_start || close_valid || glyph_adv || rect_done) mperr = 1;
                if (tag_end) begin
                    if (mblk != 0 && mdisc == 0) begin mrx = mw.bx; mry = mw.by; mph = 2; end
                    else mph = 0;
                end
                if (attr_valid && mdisc == 0) model_attr(int'(attr_type), int'(attr_value));
            end
            2: begin
                if (tag_start || close_valid || glyph_adv || rect_done || attr_valid || tag_end) mperr = 1;
                mrs = 1;
                mph = 3;
            end
            default: begin
                if (tag_start || close_valid || glyph_adv || attr_valid || tag_end) mperr = 1;
                if (rect_done) begin
                    mw.cx = (mw.bx + mw.pad) & XM;
                    mw.cy = (mw.by + mw.pad) & YM;
                    mw.lx = mw.cx;
                    mph = 0;
                end
            end
        endcase
    endtask

    always begin
        @(posedge clock or posedge reset);
        model_update();
    end

    always begin
        @(negedge clock);
        if (!reset) begin
            check("cur_x", int'(cur_x), mw.cx);
            check("cur_y", int'(cur_y), mw.cy);
            check("cur_color", int'(cur_color), mw.color);
            check("cur_size", int'(cur_size), mw.size);
            check("rect_wh", int'({rect_w, rect_h}), (mw.rw << Y_W) | mw.rh);
            check("rect_xy", int'({rect_x, rect_y}), (mrx << Y_W) | mry);
            check("rect_colors", int'({rect_bg, rect_border_color, rect_has_border}),
                  (mbg << (COLOR_W + 1)) | (mbc << 1) | mhb);
            check("rect_start", int'(rect_start), mrs);
            check("busy", int'(busy), int'(mph != 0));
            check("depth", int'(depth), mstk.size());
            check("errors", int'({overflow_err, underflow_err, proto_err}),
                  (moerr << 2) | (muerr << 1) | mperr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic open_tag(input logic b);
        tag_start = 1'b1; tag_is_block = b; step(); tag_start = 1'b0;
    endtask

    task automatic close_tag(input logic b);
        close_valid = 1'b1; tag_is_block = b; step(); close_valid = 1'b0;
    endtask

    task automatic attr(input int t, input int v);
        attr_valid = 1'b1; attr_type = 3'(t); attr_value = VAL_W'(v); step(); attr_valid = 1'b0;
    endtask

    task automatic end_tag();
        tag_end = 1'b1; step(); tag_end = 1'b0;
    endtask

    task automatic glyph();
        glyph_adv = 1'b1; step(); glyph_adv = 1'b0;
    endtask

    task automatic finish_rect();
        rect_done = 1'b1; step(); rect_done = 1'b0;
    endtask

    initial begin
        int n;
        #1;
        step();
        do_reset();
        check("reset_size", int'(cur_size), 1);
        check("reset_depth", int'(depth), 0);
        check("reset_xy", int'({cur_x, cur_y}), 0);

        // div: margin 4, padding 2, 50x20, bg 6, border color 2, text color 3
        open_tag(1'b1);
        attr(6, 4); attr(5, 2); attr(2, 50); attr(3, 20); attr(4, 6); attr(7, 2); attr(0, 3);
        end_tag();
        n = 0;
        while (rect_start !== 1'b1 && n < 8) begin step(); n++; end
        check("rect_start_delay", n, 1);
        check("rect_x", int'(rect_x), 4);
        check("rect_y", int'(rect_y), 4);
        check("rect_w", int'(rect_w), 50);
        check("rect_border", int'({rect_has_border, rect_border_color, rect_bg}), (1 << 6) | (2 << 3) | 6);
        step();
        check("rect_start_once", int'(rect_start), 0);
        finish_rect();
        check("div_cur_x", int'(cur_x), 6);
        check("div_cur_y", int'(cur_y), 6);

        // nested p: color 5, size 2, three glyphs
        open_tag(1'b0);
        attr(0, 5); attr(1, 2);
        end_tag();
        for (int i = 0; i < 3; i++) glyph();
        check("p_glyph_x", int'(cur_x), 60);
        check("p_color", int'(cur_color), 5);
        close_tag(1'b0);
        check("p_close_x", int'(cur_x), 6);
        check("p_close_y", int'(cur_y), 22);
        check("p_close_color", int'(cur_color), 3);
        check("p_close_depth", int'(depth), 1);
        close_tag(1'b1);
        check("div_close_y", int'(cur_y), 28);
        check("div_close_x", int'(cur_x), 0);
        check("div_close_depth", int'(depth), 0);

        // overflow / underflow
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin open_tag(1'b0); end_tag(); end
        check("ovf_flag", int'(overflow_err), 1);
        check("ovf_depth", int'(depth), DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) close_tag(1'b0);
        check("unf_depth", int'(depth), 0);
        check("unf_not_yet", int'(underflow_err), 0);
        close_tag(1'b0);
        check("unf_flag", int'(underflow_err), 1);

        // close beats open in the same cycle
        do_reset();
        open_tag(1'b0); end_tag();
        tag_start = 1'b1; close_valid = 1'b1; tag_is_block = 1'b0;
        step();
        tag_start = 1'b0; close_valid = 1'b0;
        check("prio_depth", int'(depth), 0);
        check("prio_busy", int'(busy), 0);

        // glyph during WAIT, then reset in WAIT
        do_reset();
        glyph(); glyph();
        open_tag(1'b1); end_tag(); step(); step();
        check("wait_busy", int'(busy), 1);
        glyph();
        check("proto_flag", int'(proto_err), 1);
        check("proto_cur_x", int'(cur_x), 18);
        reset = 1'b1;
        #1;
        check("async_rst_x", int'(cur_x), 0);
        check("async_rst_flags", int'({busy, proto_err, depth}), 0);
        check("async_rst_size", int'(cur_size), 1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_rect_after_rst", int'(rect_start), 0);
        end

        // size clamp and x wrap
        do_reset();
        open_tag(1'b0);
        attr(1, 3); attr(1, 0);
        check("size_zero", int'(cur_size), 1);
        attr(5, 3);
        end_tag();
        for (int i = 0; i < 33; i++) glyph();
        check("x_at_300", int'(cur_x), 300);
        glyph();
        check("x_at_309", int'(cur_x), 309);
        for (int i = 0; i < 24; i++) glyph();
        attr(0, 1);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
